// File: rtl/max7219_spi_writer.sv
// MAX7219 serial writer: takes one {addr, data} request at a time and shifts
// the 16-bit frame {4'h0, addr, data} MSB first to the driver chip, then
// pulses LOAD high to latch it. All serial outputs come straight from flops.
module max7219_spi_writer #(
   parameter int CLK_DIV = 2   // i_clk cycles per serial-clock half-period, 1..255
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic [3:0] i_addr,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   output logic       o_ready,
   output logic       o_done,
   output logic       o_serial_din,
   output logic       o_serial_clk,
   output logic       o_serial_load
);

   localparam int                HALF_W    = $clog2(CLK_DIV + 1);
   localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      HOLD,
      LATCH
   } state_t;

   state_t            state_q, state_d;
   logic [15:0]       shift_q, shift_d;   // shift_q[15] is the bit on DIN
   logic [HALF_W-1:0] half_q, half_d;     // cycles elapsed in current phase
   logic [3:0]        bit_q, bit_d;       // bit being sent, wraps 15 -> 0
   logic              sclk_q, sclk_d;
   logic              load_q, load_d;
   logic              done_q, done_d;
   logic              half_end;

   assign half_end      = (half_q == HALF_LAST);
   assign o_ready       = (state_q == IDLE);
   assign o_done        = done_q;
   assign o_serial_din  = shift_q[15];
   assign o_serial_clk  = sclk_q;
   assign o_serial_load = load_q;

   // State and serial-output registers; reset parks the pins in the idle pattern.
   // NOTE: the reset is asynchronous so LOAD/CLK/DIN go to their safe values
   // even with no clock running; every sequential assignment is non-blocking
   // so all flops update from the same pre-edge values.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= IDLE;
         shift_q <= '0;
         half_q  <= '0;
         bit_q   <= '0;
         sclk_q  <= 1'b0;
         load_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         half_q  <= half_d;
         bit_q   <= bit_d;
         sclk_q  <= sclk_d;
         load_q  <= load_d;
         done_q  <= done_d;
      end
   end

   // Next-state and next-output logic for the frame sequencer.
   // NOTE: every signal gets a default before the case so no path can leave
   // one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      half_d  = half_q;
      bit_d   = bit_q;
      sclk_d  = sclk_q;
      load_d  = load_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            // o_ready is high here, so i_valid alone means acceptance.
            if (i_valid) begin
               state_d = SHIFT;
               shift_d = {4'h0, i_addr, i_data};
               half_d  = '0;
               bit_d   = '0;
               sclk_d  = 1'b0;
               load_d  = 1'b0;
            end
         end

         SHIFT: begin
            if (half_end) begin
               half_d = '0;
               if (!sclk_q) begin
                  // End of low phase: raise CLK, the chip samples DIN here.
                  sclk_d = 1'b1;
               end else begin
                  // End of high phase: drop CLK and move on to the next bit.
                  sclk_d = 1'b0;
                  bit_d  = bit_q + 4'd1;
                  if (bit_q == 4'd15) begin
                     // Keep the last bit on DIN through HOLD/LATCH.
                     state_d = HOLD;
                  end else begin
                     shift_d = {shift_q[14:0], 1'b0};
                  end
               end
            end else begin
               half_d = half_q + 1'b1;
            end
         end

         HOLD: begin
            if (half_end) begin
               half_d  = '0;
               state_d = LATCH;
               load_d  = 1'b1;
               done_d  = 1'b1;
            end else begin
               half_d = half_q + 1'b1;
            end
         end

         LATCH: begin
            if (half_end) begin
               half_d  = '0;
               state_d = IDLE;
               shift_d = '0;   // DIN idles low
            end else begin
               half_d = half_q + 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
            shift_d = '0;
            half_d  = '0;
            bit_d   = '0;
            sclk_d  = 1'b0;
            load_d  = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_max7219_spi_writer.sv
// Bench for max7219_spi_writer: a MAX7219 mock decodes the serial pins, and a
// scoreboard queue holds the frames expected at each LOAD rise.
module tb_max7219_spi_writer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] addr;
   logic [7:0] data;
   logic       valid;
   logic       sel;   // 0: CLK_DIV=2 instance, 1: CLK_DIV=1 instance

   logic ready2, done2, din2, sclk2, load2;
   logic ready1, done1, din1, sclk1, load1;
   logic m_ready, m_done, m_din, m_clk, m_load;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int base     = 0;

   logic [15:0] exp_q[$];
   logic [15:0] mock_shift = '0;
   logic [7:0]  mock_reg[16];
   int          rises       = 0;
   int          total_rises = 0;
   int          frames      = 0;

   always #5 clk = ~clk;

   max7219_spi_writer #(.CLK_DIV(2)) u_dut2 (
      .i_clk(clk), .i_reset_n(rst_n), .i_addr(addr), .i_data(data),
      .i_valid(valid && !sel), .o_ready(ready2), .o_done(done2),
      .o_serial_din(din2), .o_serial_clk(sclk2), .o_serial_load(load2)
   );

   max7219_spi_writer #(.CLK_DIV(1)) u_dut1 (
      .i_clk(clk), .i_reset_n(rst_n), .i_addr(addr), .i_data(data),
      .i_valid(valid && sel), .o_ready(ready1), .o_done(done1),
      .o_serial_din(din1), .o_serial_clk(sclk1), .o_serial_load(load1)
   );

   // sel only changes while both instances idle, so the mux makes no false edges.
   assign m_ready = sel ? ready1 : ready2;
   assign m_done  = sel ? done1  : done2;
   assign m_din   = sel ? din1   : din2;
   assign m_clk   = sel ? sclk1  : sclk2;
   assign m_load  = sel ? load1  : load2;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Mock device: shift on CLK rise, latch on LOAD rise, scoreboard compare.
   always @(posedge m_clk) begin
      mock_shift = {mock_shift[14:0], m_din};
      rises++;
      total_rises++;
   end

   always @(posedge m_load) begin
      if (rst_n === 1'b1) begin
         mock_reg[mock_shift[11:8]] = mock_shift[7:0];
         frames++;
         check("sb_pending", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            check("sb_frame", 32'(mock_shift), 32'(exp_q.pop_front()));
            check("sb_rises", rises, 16);
         end
      end
      rises = 0;
   end

   // Expected pins at cycle k of a frame: {din_care, load, clk, din, done, ready}.
   function automatic logic [5:0] exp_wave(input int k, input int d, input logic [15:0] f);
      int n;
      int pos;
      if (k <= 32 * d) begin
         n   = (k - 1) / (2 * d);
         pos = (k - 1) % (2 * d);
         return {1'b1, 1'b0, (pos >= d), f[15-n], 1'b0, 1'b0};
      end else if (k <= 33 * d) begin
         return 6'b000000;
      end else if (k <= 34 * d) begin
         return {1'b0, 1'b1, 1'b0, 1'b0, (k == 33 * d + 1), 1'b0};
      end
      return 6'b110001;
   endfunction

   task automatic check_wave(input int d, input logic [15:0] f, input int kmax, input string tag);
      logic [5:0] e;
      logic [4:0] obs;
      int k;
      k = cyc - base;
      while (k <= kmax) begin
         e   = exp_wave(k, d, f);
         obs = {m_load, m_clk, (e[5] ? m_din : 1'b0), m_done, m_ready};
         check($sformatf("%s_k%0d", tag, k), 32'(obs), 32'(e[4:0]));
         @(negedge clk);
         k = cyc - base;
      end
   endtask

   task automatic accept(input logic [3:0] a, input logic [7:0] d, input bit hold);
      check("ready_pre_accept", 32'(m_ready), 1);
      addr  = a;
      data  = d;
      valid = 1'b1;
      exp_q.push_back({4'h0, a, d});
      base = cyc;
      @(negedge clk);
      if (!hold) valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n;
      n = 0;
      while (m_ready !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(m_ready), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int first_ready;
      int second_low;
      int f0;

      for (int i = 0; i < 16; i++) mock_reg[i] = 8'h00;
      sel   = 1'b0;
      valid = 1'b0;
      addr  = 4'h0;
      data  = 8'h00;
      rst_n = 1'b1;

      // Reset with no clock edge: {load, clk, din, done, ready} = 1,0,0,0,1.
      #1 rst_n = 1'b0;
      #1;
      check("rst_state_div2", 32'({m_load, m_clk, m_din, m_done, m_ready}), 32'h11);
      sel = 1'b1;
      #1;
      check("rst_state_div1", 32'({m_load, m_clk, m_din, m_done, m_ready}), 32'h11);
      sel = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Single write, full cycle-accurate waveform through return to idle.
      accept(4'h1, 8'hA5, 1'b0);
      check_wave(2, 16'h01A5, 70, "wr1");
      check("wr1_digit0", 32'(mock_reg[1]), 32'hA5);

      // Back-to-back with i_valid held.
      total_rises = 0;
      accept(4'h9, 8'hFF, 1'b1);
      addr = 4'hC;
      data = 8'h01;
      exp_q.push_back(16'h0C01);
      first_ready = -1;
      second_low  = -1;
      for (int n = 0; n < 200; n++) begin
         if (first_ready < 0 && m_ready === 1'b1) begin
            first_ready = cyc - base;
         end else if (first_ready >= 0 && m_load === 1'b0) begin
            second_low = cyc - base;
            valid = 1'b0;
            break;
         end
         @(negedge clk);
      end
      valid = 1'b0;
      check("b2b_first_ready", first_ready, 69);
      check("b2b_load_gap", second_low - first_ready, 1);
      @(negedge clk);
      wait_idle(200, "b2b_idle");
      check("b2b_reg9", 32'(mock_reg[9]), 32'hFF);
      check("b2b_regC", 32'(mock_reg[12]), 32'h01);
      check("b2b_rises", total_rises, 32);

      // Inputs changing and a stray request during a frame.
      f0 = frames;
      accept(4'h2, 8'h3C, 1'b0);
      repeat (9) @(negedge clk);
      addr = 4'hF;
      data = 8'h00;
      repeat (10) @(negedge clk);
      valid = 1'b1;
      check("stab_ready_low", 32'(m_ready), 0);
      @(negedge clk);
      valid = 1'b0;
      repeat (20) @(negedge clk);
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      wait_idle(200, "stab_idle");
      repeat (5) @(negedge clk);
      check("stab_no_extra_load", 32'(m_load), 1);
      check("stab_frames", frames - f0, 1);
      check("stab_reg2", 32'(mock_reg[2]), 32'h3C);
      check("stab_regF", 32'(mock_reg[15]), 32'h00);

      // CLK_DIV = 1 boundary: frame occupies cycles 1..34, idle at 35.
      sel = 1'b1;
      @(negedge clk);
      accept(4'hA, 8'h07, 1'b0);
      check_wave(1, 16'h0A07, 35, "div1");
      check("div1_intensity", 32'(mock_reg[10]), 32'h07);
      sel = 1'b0;
      @(negedge clk);

      // Reset during bit 7, then an immediate new write.
      accept(4'h5, 8'h55, 1'b0);
      while (cyc - base < 30) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_state", 32'({m_load, m_clk, m_din, m_done, m_ready}), 32'h11);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      accept(4'h8, 8'h3C, 1'b0);
      check("rec_busy", 32'(m_ready), 0);
      wait_idle(200, "rec_idle");
      check("rec_digit7", 32'(mock_reg[8]), 32'h3C);
      check("rec_sb_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/max7219_spi_writer.md
MAX7219_SPI_WRITER -- requirements
Module: max7219_spi_writer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, giving the number of i_clk cycles per serial-clock half-period; legal range 1..255.
REQ-002 SHALL have port i_clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port i_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port i_addr, input, 4 bits: MAX7219 register address (0x0..0xF).
REQ-005 SHALL have port i_data, input, 8 bits: register data.
REQ-006 SHALL have port i_valid, input, 1 bit: a write request is present.
REQ-007 SHALL have port o_ready, output, 1 bit: the block can accept a request this cycle.
REQ-008 SHALL have port o_done, output, 1 bit: one-cycle pulse marking the frame latch.
REQ-009 SHALL have port o_serial_din, output, 1 bit: serial data to the MAX7219 DIN pin.
REQ-010 SHALL have port o_serial_clk, output, 1 bit: serial clock to the MAX7219 CLK pin.
REQ-011 SHALL have port o_serial_load, output, 1 bit: the MAX7219 LOAD/CS pin; latches data on the rising edge.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, HOLD and LATCH, with all serial outputs driven from registers.
REQ-013 SHALL drive o_ready = 1 only in IDLE; a request is accepted in the cycle where i_valid && o_ready (cycle 0).
REQ-014 SHALL capture the 16-bit frame {4'h0, i_addr, i_data} at acceptance; input changes after cycle 0 have no effect on the frame in flight.
REQ-015 SHALL enter SHIFT in cycle 1 with o_serial_load = 0 and o_serial_clk = 0, and o_serial_din = frame bit 15.
REQ-016 SHALL shift the bits MSB first, with bit n (n = 0..15) occupying cycles 1+2*CLK_DIV*n .. 2*CLK_DIV*(n+1).
REQ-017 SHALL hold o_serial_clk = 0 for the first CLK_DIV cycles of each bit and 1 for the last CLK_DIV cycles of each bit.
REQ-018 SHALL change o_serial_din only at the start of a low phase, giving exactly 16 rising edges of o_serial_clk per frame.
REQ-019 SHALL enter HOLD after bit 15, for cycles 32*CLK_DIV+1 .. 33*CLK_DIV, with o_serial_clk = 0 and o_serial_load = 0.
REQ-020 SHALL enter LATCH for cycles 33*CLK_DIV+1 .. 34*CLK_DIV, with o_serial_load = 1 and o_serial_clk = 0.
REQ-021 SHALL assert o_done for exactly the first LATCH cycle.
REQ-022 SHALL return to IDLE at cycle 34*CLK_DIV+1 (o_ready = 1).
REQ-023 SHALL, when i_valid is held high, start the next frame's load-low in the cycle after the second acceptance, giving no idle gap beyond one cycle.
REQ-024 SHALL ignore i_valid while o_ready = 0; requests presented then are neither queued nor dropped silently (o_ready stays 0).
REQ-025 SHALL, in IDLE, hold o_serial_load = 1, o_serial_clk = 0 and o_serial_din = 0.
REQ-026 SHALL use a half-period counter of width clog2(CLK_DIV+1) and a 4-bit bit counter; bit-counter wrap from 15 terminates SHIFT.
REQ-027 SHALL, for CLK_DIV = 1, produce a frame length of 34 cycles with identical structure.

Reset
REQ-028 SHALL, while i_reset_n = 0 and irrespective of i_clk, force state IDLE and set o_serial_load = 1, o_serial_clk = 0, o_serial_din = 0, o_done = 0 and o_ready = 1.
REQ-029 SHALL resolve a reset mid-frame immediately to the REQ-028 values, with the shift register and counters cleared.
REQ-030 SHALL accept that the device latches the partial frame on that load rise; the controlling logic re-initialises the display after reset.
REQ-031 SHALL accept a new request in the first clock after reset deassertion.

Verification
REQ-032 SHALL test reset: assert i_reset_n = 0 mid-SHIFT, and check load = 1, clk = 0, din = 0, ready = 1 and done = 0 with no clock edge.
REQ-033 SHALL test a single write: with CLK_DIV = 2, addr 0x1 and data 0xA5, check that the MAX7219 mock digit0 = 0xA5, exactly 16 clk rises occur, the sampled bits are 0x01A5, done is asserted in cycle 67 and ready in cycle 69.
REQ-034 SHALL test back-to-back writes: hold i_valid with writes 0x9/0xFF then 0xC/0x01, and check both registers are updated, exactly 32 clk rises occur and the second load falls one cycle after the first ready.
REQ-035 SHALL test input stability: change i_addr/i_data and pulse i_valid during a frame, and check the transmitted frame is unchanged and the extra request is not accepted.
REQ-036 SHALL test the CLK_DIV = 1 boundary: write addr 0xA and data 0x07, check the frame spans cycles 1..34 and the mock intensity = 7.
REQ-037 SHALL test recovery: reset at bit 7, then write addr 0x8 and data 0x3C, and check the mock digit7 = 0x3C.
